// File: rtl/weight_fetch_responder.sv
// Weight fetch responder: on read_req, fetches a 16-word weight line from
// memory one word at a time, then presents it on line_out with a one-cycle
// dval pulse. Only one memory read is outstanding at a time.
// Optional feature: define WFR_BURST_COUNT_EN to add a 16-bit burst_count output.
module weight_fetch_responder #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [15:0]                base_addr,
  input  logic                       read_req,
  output logic [16*LINE_WORDS-1:0]   line_out,
  output logic                       dval,
  output logic                       busy,
  output logic                       err,
  output logic                       mem_rd_en,
  output logic [15:0]                mem_addr,
  input  logic                       mem_rd_valid,
  input  logic [15:0]                mem_rd_data
`ifdef WFR_BURST_COUNT_EN
  ,
  output logic [15:0]                burst_count
`endif
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_t;

  state_t                    state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [15:0]               cur_addr_q, cur_addr_d;
  logic                      err_q, err_d;
  logic [16*LINE_WORDS-1:0]  line_q, line_d;
`ifdef WFR_BURST_COUNT_EN
  logic [15:0]               bcnt_q, bcnt_d;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
`ifdef WFR_BURST_COUNT_EN
      bcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      err_q      <= err_d;
      line_q     <= line_d;
`ifdef WFR_BURST_COUNT_EN
      bcnt_q     <= bcnt_d;
`endif
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    err_d      = err_q;
    line_d     = line_q;
`ifdef WFR_BURST_COUNT_EN
    bcnt_d     = bcnt_q;
`endif

    busy      = (state_q != StIdle);
    dval      = (state_q == StDeliver);
    mem_rd_en = (state_q == StIssue);
    mem_addr  = mem_rd_en ? (cur_addr_q + 16'(idx_q)) : 16'h0000;

    unique case (state_q)
      StIdle: begin
        // A same-cycle load takes effect before the burst starts.
        if (load) begin
          cur_addr_d = base_addr;
          err_d      = 1'b0;
`ifdef WFR_BURST_COUNT_EN
          bcnt_d     = '0;
`endif
        end
        if (read_req) begin
          idx_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mem_rd_valid) begin
          line_d[16*idx_q +: 16] = mem_rd_data;
          if (idx_q == IdxW'(LINE_WORDS - 1)) begin
            state_d = StDeliver;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StIssue;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Abort: no dval, cur_addr left at the burst base for a retry.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDeliver: begin
        cur_addr_d = cur_addr_q + 16'(LINE_WORDS);
`ifdef WFR_BURST_COUNT_EN
        bcnt_d     = bcnt_q + 16'd1;
`endif
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests arriving mid-burst are dropped but flagged.
    if ((state_q != StIdle) && (load || read_req)) begin
      err_d = 1'b1;
    end
  end

  assign line_out = line_q;
  assign err      = err_q;
`ifdef WFR_BURST_COUNT_EN
  assign burst_count = bcnt_q;
`endif

endmodule

// File: tb/tb_weight_fetch_responder.sv
// Scoreboard bench for weight_fetch_responder: bursts push expected strobe
// addresses, lines and dval cycles; a monitor pops and compares on outputs.
module tb_weight_fetch_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [15:0]  base_addr = 16'h0000;
  logic         read_req = 1'b0;
  logic [255:0] line_out;
  logic         dval, busy, err, mem_rd_en;
  logic [15:0]  mem_addr;
  logic         mem_rd_valid = 1'b0;
  logic [15:0]  mem_rd_data = 16'h0000;
`ifdef WFR_BURST_COUNT_EN
  logic [15:0]  burst_count;
`endif

  weight_fetch_responder dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .base_addr    (base_addr),
    .read_req     (read_req),
    .line_out     (line_out),
    .dval         (dval),
    .busy         (busy),
    .err          (err),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data)
`ifdef WFR_BURST_COUNT_EN
    ,
    .burst_count  (burst_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int n_issued = 0;

  logic [15:0]  exp_addr[$];
  logic [255:0] exp_line[$];
  int           exp_cyc[$];

  logic [15:0]  model_addr = 16'h0000;
  logic [255:0] model_line = '0;

  bit           mute_en = 1'b0;
  logic [15:0]  mute_addr = 16'h0000;
  bit           pend = 1'b0;
  logic [15:0]  pend_data = 16'h0000;
  bit           late_pulse = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: answers one cycle after each strobe with addr ^ 0xA5A5.
  initial forever begin
    @(negedge clk);
    mem_rd_valid = pend || late_pulse;
    mem_rd_data  = late_pulse ? 16'hDEAD : pend_data;
    late_pulse   = 1'b0;
    pend         = mem_rd_en && !(mute_en && (mem_addr == mute_addr));
    pend_data    = mem_addr ^ 16'hA5A5;
  end

  // Monitor: checks every strobe and every dval against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mem_rd_en) begin
        n_issued++;
        if (exp_addr.size() == 0) check("unexpected_strobe", mem_addr, 16'hxxxx);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
      end else begin
        check("mem_addr_idle", mem_addr, 0);
      end
      if (dval) begin
        if (exp_line.size() == 0) begin
          check("unexpected_dval", 1, 0);
        end else begin
          check("line_out", line_out, exp_line.pop_front());
          check("dval_latency", cyc, exp_cyc.pop_front());
        end
      end
    end
  end

  // One burst from the model address; mute >= 0 withholds that word's reply.
  task automatic burst(input bit do_load, input logic [15:0] base, input int mute,
                       input bit disturb);
    logic [15:0]  a;
    logic [255:0] line;
    int k, n, words;
    @(negedge clk);
    if (do_load) model_addr = base;
    line  = model_line;
    words = (mute < 0) ? 16 : mute + 1;
    for (int i = 0; i < words; i++) begin
      a = model_addr + 16'(i);
      exp_addr.push_back(a);
      if (i != mute) line[16*i +: 16] = a ^ 16'hA5A5;
    end
    k = cyc;
    if (mute < 0) begin
      exp_line.push_back(line);
      exp_cyc.push_back(k + 33);
    end
    mute_en   = (mute >= 0);
    mute_addr = model_addr + 16'(mute);
    load      = do_load;
    base_addr = base;
    read_req  = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    read_req = 1'b0;
    if (disturb) begin
      repeat (10) @(negedge clk);
      load      = 1'b1;
      read_req  = 1'b1;
      base_addr = 16'h1234;
      @(negedge clk);
      load     = 1'b0;
      read_req = 1'b0;
    end
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("burst_done", busy, 0);
    if (mute >= 0) begin
      check("timeout_cycle", cyc, k + 2 + 2*mute + 255);
      check("timeout_err", err, 1);
    end else begin
      model_addr = model_addr + 16'd16;
    end
    mute_en    = 1'b0;
    model_line = line;
    check("line_hold", line_out, model_line);
    check("addr_q_drained", exp_addr.size(), 0);
    check("line_q_drained", exp_line.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dval", dval, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_line", line_out, 0);
`ifdef WFR_BURST_COUNT_EN
    check("rst_bcnt", burst_count, 0);
`endif
    rst = 1'b1;

    // Basic burst from 0x0100 with load and read_req in the same cycle.
    burst(1'b1, 16'h0100, -1, 1'b0);
    check("err_clean", err, 0);

    // Back-to-back bursts across the address wrap.
    burst(1'b1, 16'hFFF0, -1, 1'b0);
    burst(1'b0, 16'h0000, -1, 1'b0);
    check("wrap_addr_model", model_addr, 16'h0010);

    // Memory never answers word 3: timeout, then a retry from the same base.
    burst(1'b0, 16'h0000, 3, 1'b0);
    burst(1'b0, 16'h0000, -1, 1'b0);
    check("err_sticky", err, 1);

    // Load clears err; mid-burst load/read_req are dropped and flag err.
    burst(1'b1, 16'h0200, -1, 1'b1);
    check("disturb_err", err, 1);
    burst(1'b0, 16'h0000, -1, 1'b0);

    // Reset at word 8 of a burst.
    @(negedge clk);
    for (int i = 0; i < 9; i++) exp_addr.push_back(16'h0300 + 16'(i));
    start     = n_issued;
    load      = 1'b1;
    base_addr = 16'h0300;
    read_req  = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    read_req = 1'b0;
    n = 0;
    while (n_issued < start + 9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_word8", n_issued - start, 9);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_dval", dval, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_line", line_out, 0);
    rst        = 1'b1;
    late_pulse = 1'b1;
    model_line = '0;
    model_addr = 16'h0000;
    repeat (3) @(negedge clk);
    check("late_valid_busy", busy, 0);
    check("late_valid_line", line_out, 0);
    check("abort_q_drained", exp_addr.size(), 0);

    burst(1'b1, 16'h0040, -1, 1'b0);
    check("post_reset_err", err, 0);

`ifdef WFR_BURST_COUNT_EN
    burst(1'b1, 16'h0500, -1, 1'b0);
    burst(1'b0, 16'h0000, -1, 1'b0);
    burst(1'b0, 16'h0000, -1, 1'b0);
    check("bcnt_three", burst_count, 3);
    @(negedge clk);
    load      = 1'b1;
    base_addr = 16'h0700;
    @(negedge clk);
    load = 1'b0;
    check("bcnt_load_clear", burst_count, 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/weight_fetch_responder.md
WEIGHT_FETCH_RESPONDER -- requirements
Module: weight_fetch_responder

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles waited for mem_rd_valid per word before abort.
REQ-002 Parameter: LINE_WORDS, default 16, words per burst; fixed at 16, matching PE width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  pulse; latch base_addr as next fetch address.
REQ-006 base_addr  input  16  weight base word address.
REQ-007 read_req  input  1  accelerator burst request pulse (SRAM_read_req side).
REQ-008 line_out  output  16x16  packed burst; word i at bits [16i+15:16i].
REQ-009 dval  output  1  one-cycle pulse: line_out holds a complete burst.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 err  output  1  sticky error flag.
REQ-012 mem_rd_en  output  1  one-cycle memory read strobe.
REQ-013 mem_addr  output  16  memory word address, valid with mem_rd_en.
REQ-014 mem_rd_valid  input  1  memory read data valid.
REQ-015 mem_rd_data  input  16  memory read data.

Function
REQ-016 FSM states shall be IDLE, ISSUE, WAIT, DELIVER; one memory read outstanding at most.
REQ-017 IDLE: read_req=1 shall clear idx to 0 and go to ISSUE next cycle.
REQ-018 ISSUE: mem_rd_en=1 for exactly one cycle with mem_addr=cur_addr+idx (mod 2^16); go to WAIT.
REQ-019 WAIT: on mem_rd_valid, word idx of line_out shall be written with mem_rd_data; idx==15 -> DELIVER, else idx+1 -> ISSUE.
REQ-020 WAIT: mem_rd_valid outside WAIT shall be ignored.
REQ-021 DELIVER: dval=1 one cycle; cur_addr += 16 (wraps 0xFFF0 -> 0x0000); go to IDLE.
REQ-022 Latency with single-cycle memory: read_req to dval = 33 cycles (1 + 16x2).
REQ-023 line_out shall hold its value until overwritten word-by-word by the next burst.
REQ-024 WAIT timeout: wait counter reaching TIMEOUT without mem_rd_valid shall set err and return to IDLE with no dval; cur_addr unchanged.
REQ-025 read_req while busy shall be ignored and set err.
REQ-026 load in IDLE shall set cur_addr=base_addr and clear err.
REQ-027 load while busy shall be ignored and set err.
REQ-028 load and read_req in same IDLE cycle: burst shall start at the new base_addr.
REQ-029 mem_addr shall be 0 when mem_rd_en=0.

Reset
REQ-030 rst=0 at a clock edge shall force IDLE, idx=0, wait counter=0, cur_addr=0, err=0, dval=0, mem_rd_en=0, mem_addr=0, line_out=0.
REQ-031 Reset mid-burst shall abort the burst with no dval; a late mem_rd_valid afterwards shall be ignored.

Configuration
REQ-032 Macro WFR_BURST_COUNT_EN defined: 16-bit output burst_count, incremented on each dval, wraps 0xFFFF->0, cleared by reset and accepted load.
REQ-033 Macro WFR_BURST_COUNT_EN undefined: burst_count port and logic absent; all other behaviour identical.

Verification
REQ-034 load base_addr=0x0100, read_req, memory returns addr^0xA5A5 in 1 cycle -> 16 strobes at 0x0100..0x010F, dval 33 cycles after read_req, word i = (0x0100+i)^0xA5A5.
REQ-035 Two back-to-back bursts from 0xFFF0 -> second burst reads 0x0000..0x000F (wrap), two dval pulses.
REQ-036 Memory never responds to word 3, TIMEOUT=255 -> err=1 after 255 WAIT cycles, no dval, FSM IDLE, next burst restarts at same base.
REQ-037 read_req and load pulsed during burst -> err=1, burst completes unchanged, cur_addr unaffected by load.
REQ-038 rst=0 asserted at word 8 of a burst -> all outputs zero next cycle, no dval; following load 0x0040 + read_req completes normally.
REQ-039 WFR_BURST_COUNT_EN defined, 3 bursts -> burst_count=3; load -> burst_count=0.
